// File: rtl/rgb_stream_packer_pkg.sv
// Shared types for the RGB to 32-bit stream packer.
// Word bundle, packing phase and keep helpers.
package rgb_stream_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam logic [3:0] KEEP_FULL = 4'hF;

  typedef enum logic [1:0] {
    PH0,
    PH1,
    PH2,
    PH3
  } phase_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
  } stream_word_t;

  function automatic logic [3:0] keep_low(input int n);
    return 4'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/rgb_stream_packer_if.sv
// Pixel input and 32-bit word stream handshake bundles.
// Both use valid/ready with ready driven by the sink.
interface pixel_stream_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       valid;
  logic       sof;
  logic       eol;
  logic       ready;

  modport master(
    output r, g, b, valid, sof, eol,
    input  ready
  );
  modport slave(
    input  r, g, b, valid, sof, eol,
    output ready
  );
endinterface

interface axis_word_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master(
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );
  modport slave(
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/rgb_stream_packer_fifo.sv
// Output word FIFO: up to two pushes and one pop per cycle.
// Head reads as zero while empty so idle outputs stay clean.
module stream_word_fifo
  import rgb_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push0,
  input  stream_word_t word0,
  input  logic         push1,
  input  stream_word_t word1,
  input  logic         pop,
  output stream_word_t head,
  output logic [CW-1:0] count
);

  stream_word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= word0;
    if (push1) mem[wr_ptr + AW'(1)] <= word1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit BGR-ordered pixels into a byte-continuous
// 32-bit stream with sof on tuser and eol on tlast.
module rgb_stream_packer
  import rgb_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     aclk,
  input  logic     reset,
  pixel_stream_if.slave in_stream,
  axis_word_if.master   out_stream,
  output logic     sof_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  phase_t       phase, eff, phase_nx;
  logic [23:0]  hold, hold_nx, pix;
  logic         pend_user, user_now;
  logic         accept, norm_vld, flush_vld;
  logic         push0, push1, pop;
  stream_word_t norm, flush, word0, head;
  logic [CW-1:0] count;

  assign pix    = {in_stream.r, in_stream.g, in_stream.b};
  assign accept = in_stream.valid & in_stream.ready;
  assign eff    = in_stream.sof ? PH0 : phase;

  // Two free slots guarantee room for a word plus its flush.
  assign in_stream.ready = count <= CW'(FIFO_DEPTH - 2);

  always_comb begin
    hold_nx     = '0;
    phase_nx    = PH0;
    norm        = '0;
    flush       = '0;
    norm_vld    = 1'b0;
    flush_vld   = 1'b0;
    norm.tkeep  = KEEP_FULL;
    flush.tlast = 1'b1;
    unique case (eff)
      PH0: begin
        hold_nx     = pix;
        phase_nx    = PH1;
        flush.tdata = {8'h0, pix};
        flush.tkeep = keep_low(BYTES_PER_PIXEL);
      end
      PH1: begin
        norm_vld    = 1'b1;
        norm.tdata  = {in_stream.b, hold};
        hold_nx     = {8'h0, pix[23:8]};
        phase_nx    = PH2;
        flush.tdata = {16'h0, pix[23:8]};
        flush.tkeep = keep_low(2);
      end
      PH2: begin
        norm_vld    = 1'b1;
        norm.tdata  = {pix[15:0], hold[15:0]};
        hold_nx     = {16'h0, in_stream.r};
        phase_nx    = PH3;
        flush.tdata = {24'h0, in_stream.r};
        flush.tkeep = keep_low(1);
      end
      PH3: begin
        norm_vld   = 1'b1;
        norm.tdata = {pix, hold[7:0]};
      end
    endcase
    flush_vld  = in_stream.eol && (eff != PH3);
    norm.tlast = in_stream.eol && !flush_vld;
    if (in_stream.eol) begin
      hold_nx  = '0;
      phase_nx = PH0;
    end
    user_now = in_stream.sof | pend_user;
    if (norm_vld) norm.tuser = user_now;
    else          flush.tuser = user_now;
  end

  assign push0 = accept & (norm_vld | flush_vld);
  assign push1 = accept & norm_vld & flush_vld;
  assign word0 = norm_vld ? norm : flush;
  assign pop   = out_stream.tvalid & out_stream.tready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      phase        <= PH0;
      hold         <= '0;
      pend_user    <= 1'b0;
      sof_misalign <= 1'b0;
    end else if (accept) begin
      phase     <= phase_nx;
      hold      <= hold_nx;
      // tuser waits for the first word that holds sof bytes
      pend_user <= user_now & ~(norm_vld | flush_vld);
      if (in_stream.sof && phase != PH0) sof_misalign <= 1'b1;
    end
  end

  stream_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst   (reset),
    .push0 (push0),
    .word0 (word0),
    .push1 (push1),
    .word1 (flush),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign out_stream.tvalid = count != '0;
  assign out_stream.tdata  = head.tdata;
  assign out_stream.tkeep  = head.tkeep;
  assign out_stream.tlast  = head.tlast;
  assign out_stream.tuser  = head.tuser;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: vector table, byte-level
// reference model and an in-order word scoreboard.
module tb_rgb_stream_packer;
  import rgb_stream_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]   r, g, b;
    logic         sof, eol;
    int           n;
    stream_word_t w0, w1;
  } vec_t;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  logic sof_misalign;

  always #5 aclk = ~aclk;

  pixel_stream_if in_if();
  axis_word_if    out_if();

  rgb_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .reset        (reset),
    .in_stream    (in_if),
    .out_stream   (out_if),
    .sof_misalign (sof_misalign)
  );

  int n_tests = 0;
  int n_fail  = 0;
  stream_word_t exp_q[$];
  logic [7:0]   mb[$];
  bit m_user = 0;
  bit mon_en = 0;
  bit bp_mode = 0;
  bit frame_chk = 0;
  logic tready_force = 1'b1;
  int words_seen = 0, last_seen = 0, user_seen = 0, line_words = 0;
  vec_t vt[20];

  function automatic stream_word_t sw(input logic [31:0] d,
                                      input logic [3:0] k,
                                      input logic l, input logic u);
    stream_word_t w;
    w.tdata = d;
    w.tkeep = k;
    w.tlast = l;
    w.tuser = u;
    return w;
  endfunction

  function automatic vec_t mv(input logic [7:0] r, g, b,
                              input logic sof, eol, input int n,
                              input stream_word_t w0, w1);
    vec_t v;
    v.r = r; v.g = g; v.b = b;
    v.sof = sof; v.eol = eol; v.n = n;
    v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge aclk) begin
    #2;
    out_if.tready = bp_mode ? ($urandom_range(0, 99) < 30) : tready_force;
  end

  stream_word_t hw, ew, prev_w;
  bit prev_stall = 0;

  always @(negedge aclk) begin
    if (mon_en) begin
      hw = sw(out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser);
      check("in_ready", 64'(in_if.ready), 64'(exp_q.size() <= DEPTH - 2));
      if (prev_stall) begin
        check("stall_valid", 64'(out_if.tvalid), 64'(1));
        check("stall_word", 64'(hw), 64'(prev_w));
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: got %h expected none", hw);
        end else begin
          ew = exp_q.pop_front();
          check("word", 64'(hw), 64'(ew));
        end
        words_seen++;
        line_words++;
        if (hw.tuser) user_seen++;
        if (hw.tlast) begin
          last_seen++;
          if (frame_chk) check("line_words", 64'(line_words), 64'(480));
          line_words = 0;
        end
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_w = hw;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send_pix(input logic [7:0] r, g, b, input logic sof, eol);
    int t = 0;
    in_if.r = r; in_if.g = g; in_if.b = b;
    in_if.sof = sof; in_if.eol = eol; in_if.valid = 1'b1;
    while (!in_if.ready && t < 500) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (t >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end else begin
      @(posedge aclk);
      #1;
    end
    in_if.valid = 1'b0;
  endtask

  task automatic model_pix(input logic [7:0] r, g, b, input logic sof, eol);
    stream_word_t w;
    int n;
    if (sof) begin
      mb.delete();
      m_user = 1;
    end
    mb.push_back(b);
    mb.push_back(g);
    mb.push_back(r);
    if (mb.size() >= 4) begin
      w = '0;
      for (int i = 0; i < 4; i++) w.tdata[8*i +: 8] = mb.pop_front();
      w.tkeep = 4'hF;
      w.tlast = eol && (mb.size() == 0);
      w.tuser = m_user;
      m_user = 0;
      exp_q.push_back(w);
    end
    if (eol && mb.size() != 0) begin
      w = '0;
      n = mb.size();
      for (int i = 0; i < n; i++) w.tdata[8*i +: 8] = mb.pop_front();
      w.tkeep = 4'((1 << n) - 1);
      w.tlast = 1'b1;
      w.tuser = m_user;
      m_user = 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic send_model(input logic [7:0] r, g, b, input logic sof, eol);
    send_pix(r, g, b, sof, eol);
    model_pix(r, g, b, sof, eol);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bit was_empty;
      send_pix(vt[i].r, vt[i].g, vt[i].b, vt[i].sof, vt[i].eol);
      was_empty = exp_q.size() == 0;
      if (vt[i].n > 0) exp_q.push_back(vt[i].w0);
      if (vt[i].n > 1) exp_q.push_back(vt[i].w1);
      if (vt[i].n > 0 && was_empty)
        check("latency_tvalid", 64'(out_if.tvalid), 64'(1));
    end
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(posedge aclk);
      t++;
    end
    repeat (2) @(posedge aclk);
    #1;
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 64'(out_if.tvalid), 64'(0));
    check({tag, "_tdata"}, 64'(out_if.tdata), 64'(0));
    check({tag, "_tkeep"}, 64'(out_if.tkeep), 64'(0));
    check({tag, "_tlast"}, 64'(out_if.tlast), 64'(0));
    check({tag, "_tuser"}, 64'(out_if.tuser), 64'(0));
    check({tag, "_misalign"}, 64'(sof_misalign), 64'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_word_t z;
    z = '0;
    vt[0]  = mv(8'h11, 8'h22, 8'h33, 1, 0, 0, z, z);
    vt[1]  = mv(8'h44, 8'h55, 8'h66, 0, 0, 1, sw(32'h66112233, 4'hF, 0, 1), z);
    vt[2]  = mv(8'h77, 8'h88, 8'h99, 0, 0, 1, sw(32'h88994455, 4'hF, 0, 0), z);
    vt[3]  = mv(8'hAA, 8'hBB, 8'hCC, 0, 0, 1, sw(32'hAABBCC77, 4'hF, 0, 0), z);
    vt[4]  = mv(8'h11, 8'h22, 8'h33, 0, 0, 0, z, z);
    vt[5]  = mv(8'h44, 8'h55, 8'h66, 0, 1, 2, sw(32'h66112233, 4'hF, 0, 0),
                sw(32'h00004455, 4'h3, 1, 0));
    vt[6]  = mv(8'h01, 8'h02, 8'h03, 1, 1, 1, sw(32'h00010203, 4'h7, 1, 1), z);
    vt[7]  = mv(8'h10, 8'h20, 8'h30, 0, 0, 0, z, z);
    vt[8]  = mv(8'h40, 8'h50, 8'h60, 0, 0, 1, sw(32'h60102030, 4'hF, 0, 0), z);
    vt[9]  = mv(8'h70, 8'h80, 8'h90, 0, 1, 2, sw(32'h80904050, 4'hF, 0, 0),
                sw(32'h00000070, 4'h1, 1, 0));
    vt[10] = mv(8'h01, 8'h02, 8'h03, 0, 0, 0, z, z);
    vt[11] = mv(8'h04, 8'h05, 8'h06, 0, 0, 1, sw(32'h06010203, 4'hF, 0, 0), z);
    vt[12] = mv(8'h07, 8'h08, 8'h09, 0, 0, 1, sw(32'h08090405, 4'hF, 0, 0), z);
    vt[13] = mv(8'h0A, 8'h0B, 8'h0C, 0, 1, 1, sw(32'h0A0B0C07, 4'hF, 1, 0), z);
    vt[14] = mv(8'h21, 8'h22, 8'h23, 1, 0, 0, z, z);
    vt[15] = mv(8'h31, 8'h32, 8'h33, 0, 1, 2, sw(32'h33212223, 4'hF, 0, 1),
                sw(32'h00003132, 4'h3, 1, 0));
    vt[16] = mv(8'h11, 8'h22, 8'h33, 0, 0, 0, z, z);
    vt[17] = mv(8'h44, 8'h55, 8'h66, 0, 0, 1, sw(32'h66112233, 4'hF, 0, 0), z);
    vt[18] = mv(8'h77, 8'h88, 8'h99, 1, 0, 0, z, z);
    vt[19] = mv(8'hAA, 8'hBB, 8'hCC, 0, 0, 1, sw(32'hCC778899, 4'hF, 0, 1), z);

    in_if.valid = 1'b0; in_if.sof = 1'b0; in_if.eol = 1'b0;
    in_if.r = '0; in_if.g = '0; in_if.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    reset = 1'b0;
    check_idle("reset");
    check("reset_ready", 64'(in_if.ready), 64'(1));

    mon_en = 1;
    run_table(0, 15);
    drain(200);
    check("table_misalign", 64'(sof_misalign), 64'(0));

    // Four 640-pixel lines at full rate.
    words_seen = 0; last_seen = 0; user_seen = 0; line_words = 0;
    frame_chk = 1;
    for (int ln = 0; ln < 4; ln++) begin
      for (int px = 0; px < 640; px++) begin
        send_model(8'($urandom), 8'($urandom), 8'($urandom),
                   ln == 0 && px == 0, px == 639);
      end
    end
    drain(500);
    frame_chk = 0;
    check("frame_words", 64'(words_seen), 64'(1920));
    check("frame_tlast", 64'(last_seen), 64'(4));
    check("frame_tuser", 64'(user_seen), 64'(1));
    check("frame_misalign", 64'(sof_misalign), 64'(0));

    // Random backpressure with random line ends.
    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      send_model(8'($urandom), 8'($urandom), 8'($urandom),
                 i == 0, i == 199 || $urandom_range(0, 9) == 0);
    end
    drain(4000);
    bp_mode = 0;
    check("bp_misalign", 64'(sof_misalign), 64'(0));

    run_table(16, 19);
    drain(200);
    check("misalign_set", 64'(sof_misalign), 64'(1));

    // Reset in the middle of a stalled line.
    mon_en = 0;
    tready_force = 1'b0;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_if.r = 8'(i); in_if.g = 8'(i + 1); in_if.b = 8'(i + 2);
      in_if.sof = 1'(i == 0); in_if.eol = 1'b0; in_if.valid = 1'b1;
      @(posedge aclk);
      #1;
    end
    in_if.valid = 1'b0;
    check("stalled_tvalid", 64'(out_if.tvalid), 64'(1));
    reset = 1'b1;
    @(posedge aclk);
    #1;
    reset = 1'b0;
    check_idle("midreset");
    check("midreset_ready", 64'(in_if.ready), 64'(1));
    exp_q.delete();
    mb.delete();
    m_user = 0;
    tready_force = 1'b1;
    @(posedge aclk);
    #1;
    mon_en = 1;
    run_table(0, 3);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
